// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared types for the RV32 pipeline hazard/forwarding logic.
//   fwd_sel_t   : operand-select code driven into the EX forwarding muxes
//   stage_tag_t : destination info tracked for one in-flight instruction
//   TAG_BUBBLE  : tag value of an empty pipeline slot
//   tag_writes  : true when a tag is a live producer of a given register
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,  // register file / immediate path
    FWD_WB   = 2'd1,  // wbResult, producer now in WB
    FWD_ALU  = 2'd2,  // aluResultWb, producer now in MEM
    FWD_ZERO = 2'd3   // constant zero, never generated here
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regWrite;
    logic                  memRead;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '{
    valid:    1'b0,
    rd:       {REG_ADDR_W{1'b0}},
    regWrite: 1'b0,
    memRead:  1'b0
  };

  // A slot produces rs when it holds a real instruction that writes rs.
  function automatic logic tag_writes(input stage_tag_t t,
                                      input logic [REG_ADDR_W-1:0] rs);
    return t.valid && t.regWrite && (t.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match
// Compares one ID source operand against the EX and MEM shadow tags.
// Build option: HAZARD_FWD_EN selects the forwarding code; without it the
// select output is constant FWD_NONE.
// Ports:
//   uses_i      - the instruction actually reads this operand
//   rs_i        - source register index
//   ex_tag_i    - tag of the instruction currently in EX
//   mem_tag_i   - tag of the instruction currently in MEM
//   match_ex_o  - EX instruction produces rs_i
//   match_mem_o - MEM instruction produces rs_i
//   sel_o       - forwarding select for this operand (youngest producer wins)
module hazard_match
  import pipeline_pkg::*;
(
  input  logic                  uses_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  stage_tag_t            ex_tag_i,
  input  stage_tag_t            mem_tag_i,
  output logic                  match_ex_o,
  output logic                  match_mem_o,
  output fwd_sel_t              sel_o
);

  logic reads_real_reg_s;
  logic unused_tag_bits_s;

  // Load flags are judged by the top; they are not needed for matching.
  assign unused_tag_bits_s = ex_tag_i.memRead ^ mem_tag_i.memRead;

  // Operand matches; x0 is hard-wired zero and never matches.
  always_comb begin
    reads_real_reg_s = uses_i && (rs_i != {REG_ADDR_W{1'b0}});
    match_ex_o       = reads_real_reg_s && tag_writes(ex_tag_i, rs_i);
    match_mem_o      = reads_real_reg_s && tag_writes(mem_tag_i, rs_i);
  end

  // Forwarding select: EX producer is younger than MEM producer, so it wins.
  always_comb begin
    sel_o = FWD_NONE;
`ifdef HAZARD_FWD_EN
    if (match_ex_o) begin
      sel_o = FWD_ALU;
    end else if (match_mem_o) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_NONE;
    end
`else
    sel_o = FWD_NONE;
`endif
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit
// Hazard detection and operand-forwarding control for the 5-stage RV32 core.
// Shadows the destination tags of instructions in EX, MEM and WB, registers
// the forwarding selects for the instruction entering EX, and detects the
// hazards that force the ID instruction to wait.
// Build option: HAZARD_FWD_EN enables forwarding. Without it the selects are
// always 0 and the ID instruction waits until its producer reaches WB.
// Ports:
//   clk, resetn       - clock; asynchronous reset, active high
//   id_*              - decoded fields of the instruction in ID
//   flush             - taken branch/jump in EX, kills ID and EX
//   freeze            - global hold, no state advances
//   selOp1, selOp2    - registered forwarding selects for the EX instruction
//   stall             - hold PC and IF/ID this cycle (combinational)
//   exBubble          - the instruction now in EX is an inserted bubble
//   stallCount        - saturating number of stall cycles taken
module hazard_forward_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_usesRs1,
  input  logic                  id_usesRs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regWrite,
  input  logic                  id_memRead,
  input  logic                  flush,
  input  logic                  freeze,
  output logic [1:0]            selOp1,
  output logic [1:0]            selOp2,
  output logic                  stall,
  output logic                  exBubble,
  output logic [CNT_W-1:0]      stallCount
);

  import pipeline_pkg::*;

  stage_tag_t       id_tag_s;
  stage_tag_t       ex_q, ex_d;
  stage_tag_t       mem_q, mem_d;
  stage_tag_t       wb_q, wb_d;
  logic [1:0]       selOp1_q, selOp1_d;
  logic [1:0]       selOp2_q, selOp2_d;
  logic             exBubble_q, exBubble_d;
  logic [CNT_W-1:0] stallCount_q, stallCount_d;

  logic             ex1_s, mem1_s, ex2_s, mem2_s;
  fwd_sel_t         fsel1_s, fsel2_s;
  logic [1:0]       nsel1_s, nsel2_s;
  logic             hazard_s;
  logic             insert_bubble_s;
  logic             unused_bits_s;

  // Destination info of the ID instruction, as it would enter EX.
  always_comb begin
    id_tag_s          = TAG_BUBBLE;
    id_tag_s.valid    = id_valid;
    id_tag_s.rd       = id_rd;
    id_tag_s.regWrite = id_regWrite;
    id_tag_s.memRead  = id_memRead;
  end

  hazard_match u_match_rs1 (
    .uses_i      (id_usesRs1),
    .rs_i        (id_rs1),
    .ex_tag_i    (ex_q),
    .mem_tag_i   (mem_q),
    .match_ex_o  (ex1_s),
    .match_mem_o (mem1_s),
    .sel_o       (fsel1_s)
  );

  hazard_match u_match_rs2 (
    .uses_i      (id_usesRs2),
    .rs_i        (id_rs2),
    .ex_tag_i    (ex_q),
    .mem_tag_i   (mem_q),
    .match_ex_o  (ex2_s),
    .match_mem_o (mem2_s),
    .sel_o       (fsel2_s)
  );

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign nsel1_s       = fsel1_s;
  assign nsel2_s       = fsel2_s;
  assign unused_bits_s = ^{wb_q, mem1_s, mem2_s};
`else
  // No bypass paths: selects stay on the register file.
  assign nsel1_s       = FWD_NONE;
  assign nsel2_s       = FWD_NONE;
  assign unused_bits_s = ^{wb_q, fsel1_s, fsel2_s};
`endif

  // Hazard detection; a flush kills the ID instruction so it never stalls.
  always_comb begin
    hazard_s = 1'b0;
`ifdef HAZARD_FWD_EN
    if (id_valid && ex_q.memRead) begin
      hazard_s = ex1_s || ex2_s;
    end else begin
      hazard_s = 1'b0;
    end
`else
    if (id_valid) begin
      hazard_s = ex1_s || ex2_s || mem1_s || mem2_s;
    end else begin
      hazard_s = 1'b0;
    end
`endif
    stall           = hazard_s && !flush;
    insert_bubble_s = flush || stall;
  end

  // Next state: freeze holds everything, otherwise the shadow pipe advances.
  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    selOp1_d     = selOp1_q;
    selOp2_d     = selOp2_q;
    exBubble_d   = exBubble_q;
    stallCount_d = stallCount_q;
    if (freeze) begin
      ex_d = ex_q;
    end else begin
      // MEM/WB always move on; on flush MEM receives the branch itself.
      mem_d      = ex_q;
      wb_d       = mem_q;
      exBubble_d = insert_bubble_s;
      if (insert_bubble_s) begin
        ex_d     = TAG_BUBBLE;
        selOp1_d = FWD_NONE;
        selOp2_d = FWD_NONE;
      end else begin
        ex_d     = id_tag_s;
        selOp1_d = nsel1_s;
        selOp2_d = nsel2_s;
      end
      if (stall && (stallCount_q != {CNT_W{1'b1}})) begin
        stallCount_d = stallCount_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stallCount_d = stallCount_q;
      end
    end
  end

  // State registers; async clear of the EX tag drops stall immediately.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      ex_q         <= TAG_BUBBLE;
      mem_q        <= TAG_BUBBLE;
      wb_q         <= TAG_BUBBLE;
      selOp1_q     <= FWD_NONE;
      selOp2_q     <= FWD_NONE;
      exBubble_q   <= 1'b0;
      stallCount_q <= {CNT_W{1'b0}};
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      selOp1_q     <= selOp1_d;
      selOp2_q     <= selOp2_d;
      exBubble_q   <= exBubble_d;
      stallCount_q <= stallCount_d;
    end
  end

  assign selOp1     = selOp1_q;
  assign selOp2     = selOp2_q;
  assign exBubble   = exBubble_q;
  assign stallCount = stallCount_q;

endmodule
